// File: rtl/core_pkg.sv
// Shared constants and types for the RV32/RV64 core front end.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN_DEFAULT-1:0] RESET_VECTOR_DEFAULT = '0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [ILEN-1:0]         instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction buffer; flush empties it, pointers wrap at DEPTH (a power of 2).
module fetch_fifo
  import core_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  entry_t                 push_data,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  entry_t          mem [DEPTH];
  logic [AW-1:0]   wptr;
  logic [AW-1:0]   rptr;
  logic            full;
  logic            do_pop;

  assign full   = (count == (AW+1)'(DEPTH));
  assign do_pop = pop && (count != '0);
  assign head   = mem[rptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)   wptr <= wptr + AW'(1);
      if (do_pop) rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= push_data;
  end

  // The fetch credit scheme must never let a response land in a full buffer.
  assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC ownership, credit-limited pipelined requests, redirect flush.
// Optional FETCH_PERF_CNT_EN adds saturating stall/flush performance counters.
module fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN            = XLEN_DEFAULT,
  parameter int              ILEN            = core_pkg::ILEN,
  parameter int              DEPTH           = 4,
  parameter int              MAX_OUTSTANDING = 2,
  parameter logic [XLEN-1:0] RESET_VECTOR    = XLEN'(RESET_VECTOR_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            reset_pc,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ack,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  input  logic            instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cnt,
  output logic [31:0]     perf_flush_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int SW = $clog2(DEPTH + MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] flush_target;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   outstanding_next;
  logic [OW-1:0]   drop_cnt;
  logic [AW:0]     occupancy;
  logic [SW-1:0]   credit_sum;
  logic            flush;
  logic            accept;
  logic            rsp_keep;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;

  assign flush        = reset_pc || redirect_valid;
  assign flush_target = reset_pc ? RESET_VECTOR : (redirect_pc & ~XLEN'(3));

  // In-flight requests reserve buffer slots, so every response is guaranteed a home.
  assign credit_sum       = SW'(outstanding) + SW'(occupancy);
  assign imem_req_valid   = !reset && !flush && (credit_sum < SW'(DEPTH)) &&
                            (outstanding < OW'(MAX_OUTSTANDING));
  assign imem_req_addr    = fetch_pc;
  assign accept           = imem_req_valid && imem_req_ack;
  assign outstanding_next = outstanding + OW'(accept) - OW'(imem_rsp_valid);
  assign rsp_keep         = imem_rsp_valid && (drop_cnt == '0) && !flush;

  assign pop         = instr_valid && instr_ready;
  assign instr_valid = (occupancy != '0);
  assign instr_data  = head_entry.instr;
  assign instr_pc    = head_entry.pc;
  assign push_entry  = '{pc: resp_pc, instr: imem_rsp_data};

  // After a flush, everything still in flight belongs to the old stream and is discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (flush) begin
        fetch_pc <= flush_target;
        resp_pc  <= flush_target;
        drop_cnt <= outstanding_next;
      end else begin
        if (accept)   fetch_pc <= fetch_pc + XLEN'(4);
        if (rsp_keep) resp_pc  <= resp_pc + XLEN'(4);
        if (imem_rsp_valid && (drop_cnt != '0)) drop_cnt <= drop_cnt - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .push      (rsp_keep),
    .pop       (pop),
    .push_data (push_entry),
    .head      (head_entry),
    .count     (occupancy)
  );

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (instr_ready && !instr_valid && (perf_stall_cnt != '1))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (flush && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs. a stream-level model.
`timescale 1ns/1ps
module tb_fetch_unit;
  import core_pkg::*;

  localparam logic [31:0] RV = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset, reset_pc;
  logic        imem_req_valid, imem_req_ack, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr_data, instr_pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  fetch_unit #(
    .XLEN            (32),
    .ILEN            (32),
    .DEPTH           (4),
    .MAX_OUTSTANDING (2),
    .RESET_VECTOR    (RV)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .reset_pc       (reset_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ack   (imem_req_ack),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_stall_cnt (perf_stall_cnt),
    .perf_flush_cnt (perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  pend_t       pend[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          lat = 1;
  int          pops = 0;
  int          accepts = 0;
  int          stall_model = 0;
  int          flush_model = 0;
  logic [31:0] model_req_pc, exp_pc;
  logic        hold_prev = 1'b0;
  logic        flush_prev = 1'b0;
  logic        last_valid, last_accept;
  logic [31:0] last_addr;
  logic        saw_zero_req = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One cycle: drive at posedge+1, observe at negedge, update the stream model.
  task automatic applyStimulus(input logic ack, input logic ready, input logic rv,
                               input logic [31:0] rpc, input logic rp);
    logic        flushing;
    logic [31:0] target;
    imem_req_ack   = ack;
    instr_ready    = ready;
    redirect_valid = rv;
    redirect_pc    = rpc;
    reset_pc       = rp;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(pend[0].addr);
      void'(pend.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = NOP_INSTR;
    end
    @(negedge clk);
    flushing = rp || rv;
    target   = rp ? RV : (rpc & ~32'h3);
    if (flushing) checkOutput("req_blocked_on_flush", imem_req_valid, 1'b0);
    if (hold_prev && !flushing) checkOutput("req_held", imem_req_valid, 1'b1);
    if (flush_prev) checkOutput("empty_after_flush", instr_valid, 1'b0);
    if (imem_req_valid) checkOutput("req_addr", imem_req_addr, model_req_pc);
    last_valid  = imem_req_valid;
    last_addr   = imem_req_addr;
    last_accept = imem_req_valid && ack;
    if (last_accept) begin
      pend.push_back('{imem_req_addr, cyc + lat});
      model_req_pc += 32'd4;
      accepts++;
      if (imem_req_addr == 32'h0) saw_zero_req = 1'b1;
    end
    if (instr_valid && ready) begin
      checkOutput("instr_pc", instr_pc, exp_pc);
      checkOutput("instr_data", instr_data, mem_word(exp_pc));
      exp_pc += 32'd4;
      pops++;
    end
    if (ready && !instr_valid) stall_model++;
    if (flushing) begin
      flush_model++;
      model_req_pc = target;
      exp_pc       = target;
    end
    if (pend.size() > 2) checkOutput("outstanding_max", pend.size(), 2);
    hold_prev  = imem_req_valid && !ack;
    flush_prev = flushing;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int a0, p0;
    reset = 1'b1; reset_pc = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ack = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = NOP_INSTR; instr_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("reset_req_valid", imem_req_valid, 1'b0);
    checkOutput("reset_instr_valid", instr_valid, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    model_req_pc = RV;
    exp_pc       = RV;

    $display("[TB] streaming at latency 1");
    lat = 1;
    repeat (6) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    p0 = pops;
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("throughput", pops - p0, 10);

    $display("[TB] fill with decode stalled");
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
    a0 = accepts;
    repeat (12) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("fill_accepts", accepts - a0, 4);
    checkOutput("fill_head_valid", instr_valid, 1'b1);
    checkOutput("fill_req_stopped", imem_req_valid, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    a0 = accepts;
    repeat (8) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
    checkOutput("refill_one", accepts - a0, 1);

    $display("[TB] ack held low");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    a0 = accepts;
    for (int i = 0; i < 10 && (accepts - a0) < 2; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("two_accepts", accepts - a0, 2);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      checkOutput("stall_valid", last_valid, 1'b1);
      checkOutput("stall_addr", last_addr, 32'h0000_1008);
    end
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("stall_accept", last_accept, 1'b1);
    checkOutput("stall_accept_addr", last_addr, 32'h0000_1008);

    $display("[TB] redirect with responses in flight");
    lat = 3;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 10 && pend.size() < 2; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("two_inflight", pend.size(), 2);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_2000, 1'b0);
    p0 = pops;
    repeat (15) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("redirect_delivers", (pops > p0), 1'b1);

    $display("[TB] priority, wrap and alignment");
    lat = 1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_3000, 1'b1);
    p0 = pops;
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("reset_pc_delivers", (pops > p0), 1'b1);
    saw_zero_req = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    repeat (10) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("pc_wrap", saw_zero_req, 1'b1);
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h0000_4003, 1'b0);
    p0 = pops;
    repeat (8) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    checkOutput("unaligned_delivers", (pops > p0), 1'b1);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      lat = int'($urandom_range(1, 4));
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 6,
                    $urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 99) < 1);
    end

`ifdef FETCH_PERF_CNT_EN
    checkOutput("perf_stall_cnt", perf_stall_cnt, stall_model);
    checkOutput("perf_flush_cnt", perf_flush_cnt, flush_model);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised instruction-fetch front end for the RV32/RV64 core family.
- Owns the PC and issues pipelined requests to instruction memory using a valid/ack request handshake and in-order responses.
- Buffers returned instructions, with their PCs, in a DEPTH-entry queue feeding decode.
- Supports redirects from branch/jump resolution, and discards stale in-flight responses after a redirect.

Parameters:
- XLEN, 32, address/PC width (32 or 64).
- ILEN, 32, instruction word width.
- DEPTH, 4, instruction-buffer entries (power of 2, ≥2).
- MAX_OUTSTANDING, 2, maximum issued-but-unreturned memory requests (≤ DEPTH).
- RESET_VECTOR, 0, PC loaded on reset or reset_pc.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- reset_pc  in  1  synchronous PC reload to RESET_VECTOR; flushes like a redirect.
- imem_req_valid  out  1  request valid.
- imem_req_addr  out  XLEN  request address (word aligned).
- imem_req_ack  in  1  request accepted this cycle when valid && ack.
- imem_rsp_valid  in  1  response data valid; responses arrive in order, latency ≥1 cycle after accept.
- imem_rsp_data  in  ILEN  response instruction word.
- redirect_valid  in  1  branch/jump redirect.
- redirect_pc  in  XLEN  redirect target.
- instr_valid  out  1  buffer head valid.
- instr_data  out  ILEN  buffer head instruction.
- instr_pc  out  XLEN  buffer head PC.
- instr_ready  in  1  decode consumes head when valid && ready.

Behaviour:
- One clock, clk. reset is synchronous and active-high.
- Reset values:
  - fetch_pc = RESET_VECTOR.
  - Buffer empty; instr_valid = 0.
  - imem_req_valid = 0 in the reset cycle.
  - outstanding = 0; drop_cnt = 0.
- Request issue:
  - imem_req_valid = 1 iff (outstanding + occupancy) < DEPTH, outstanding < MAX_OUTSTANDING, and no redirect/reset_pc is active this cycle.
  - imem_req_addr = fetch_pc.
  - On accept (valid && ack): fetch_pc += 4 (XLEN wrap-around modulo 2^XLEN), and outstanding increments.
  - While ack is low, addr and valid are held stable; valid never drops without an accept unless a redirect occurs.
- Response:
  - Each imem_rsp_valid decrements outstanding.
  - If drop_cnt > 0, the response is discarded and drop_cnt decrements.
  - Otherwise the response is written to the buffer with its PC, taken from a per-request PC queue (or equivalently a resp_pc counter).
  - The credit rule guarantees the buffer never overflows. A response arriving into a full buffer is an assertion failure.
- Dequeue: head pops on instr_valid && instr_ready. instr_data and instr_pc are registered from buffer storage; zero-latency bypass from response to output is not required.
- Simultaneous events:
  - Accept, response and pop in the same cycle are all honoured; outstanding and occupancy update by net effect.
- Redirect (redirect_valid, or reset_pc with target RESET_VECTOR):
  - Next cycle: buffer emptied and fetch_pc = target.
  - drop_cnt = outstanding after this cycle's accept/response; a response in the redirect cycle is itself dropped.
  - instr_valid = 0 the cycle after the redirect.
  - A request is not issued in the redirect cycle; issue resumes the following cycle.
  - reset_pc and redirect_valid together: reset_pc wins.
- Priority: reset > reset_pc > redirect_valid > normal operation.
- Unaligned redirect_pc: the low 2 bits are forced to 0.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output perf_stall_cnt (32 bits) and perf_flush_cnt (32 bits).
  - perf_stall_cnt counts cycles with instr_ready=1 and instr_valid=0.
  - perf_flush_cnt counts redirect/reset_pc events.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package core_pkg holds:
  - XLEN_DEFAULT and ILEN constants;
  - RESET_VECTOR_DEFAULT;
  - typedef fetch_entry_t {pc, instr};
  - NOP encoding 32'h0000_0013 for bench use.
- One sub-module, fetch_fifo: a synchronous circular buffer of fetch_entry_t with count, push/pop, and a flush input. Its read pointer wraps at DEPTH.

Test Plan:
- Reset with RESET_VECTOR=32'h0000_1000, memory acks every cycle, latency 1 -> requests to 0x1000, 0x1004, 0x1008…; instr_pc follows the same sequence; throughput is 1 instr/cycle once filled.
- Hold instr_ready=0, DEPTH=4, MAX_OUTSTANDING=2 -> exactly 4 requests accepted and buffer full; imem_req_valid=0 until the first pop, then exactly one new request.
- imem_req_ack low for 3 cycles -> imem_req_addr stays stable at 0x1008 with valid high; accept on the 4th cycle.
- Latency-3 memory with 2 outstanding, redirect_pc=0x2000 -> both in-flight responses dropped; the next delivered instr_pc is 0x2000; no 0x100x PC reaches decode after the redirect.
- redirect_valid (0x3000) and reset_pc asserted in the same cycle -> fetch resumes at 0x1000. Separately, XLEN=32 with PC 0xFFFF_FFFC -> the next request wraps to 0x0000_0000.
- With FETCH_PERF_CNT_EN: 5 starved cycles and 2 redirects -> perf_stall_cnt=5, perf_flush_cnt=2. Without the macro, the build elaborates without those ports.
